// File: rtl/load_use_interlock.sv
// load_use_interlock
//   Decode-side hazard controller for the 5-stage pipeline. It keeps a shadow
//   copy of the destination info for the instructions in EXE and MEM. It holds
//   decode while a consumer needs a load result that the forwarding network
//   cannot supply yet. It also provides flush, a stall watchdog and perf counters.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   flush               invalidate both shadow slots
//   ds_*                decode-stage instruction (sources, uses, dest, is_load)
//   es_allow_in         EXE can accept an instruction
//   es_fire / ms_fire   EXE->MEM / MEM->WB handoff this cycle
//   stall               hold decode (combinational)
//   stall_reason        {load in MEM, load in EXE}
//   ds_fire             decode hands its instruction to EXE
//   stall_timeout       sticky watchdog flag
//   stall_cnt           total stall cycles
//   hazard_cnt          distinct stall events (rising edges of stall)
module load_use_interlock #(
  parameter int LOAD_LAT  = 1,
  parameter int MAX_STALL = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ds_valid,
  input  logic [4:0]  ds_raddr1,
  input  logic [4:0]  ds_raddr2,
  input  logic        ds_use1,
  input  logic        ds_use2,
  input  logic        ds_is_load,
  input  logic        ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic        es_allow_in,
  input  logic        es_fire,
  input  logic        ms_fire,
  output logic        stall,
  output logic [1:0]  stall_reason,
  output logic        ds_fire,
  output logic        stall_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] hazard_cnt
);

  typedef struct packed {
    logic       v;
    logic       ld;
    logic       we;
    logic [4:0] waddr;
  } slot_t;

  // With a two-stage load latency the result is still unavailable while the
  // load sits in MEM, so the MEM slot joins the hazard check.
  localparam logic       MS_CHECK    = (LOAD_LAT == 2);
  localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);

  slot_t      es_slot, ms_slot;
  logic [7:0] run_cnt, run_nxt;
  logic       prev_stall;
  logic       hz_es, hz_ms;

  function automatic logic match(input slot_t s, input logic [4:0] r, input logic u);
    return s.v & s.ld & s.we & (s.waddr != 5'd0) & (s.waddr == r) & u;
  endfunction

  always_comb begin
    hz_es        = match(es_slot, ds_raddr1, ds_use1) | match(es_slot, ds_raddr2, ds_use2);
    hz_ms        = MS_CHECK & (match(ms_slot, ds_raddr1, ds_use1) | match(ms_slot, ds_raddr2, ds_use2));
    stall        = ds_valid & (hz_es | hz_ms);
    stall_reason = {2{ds_valid}} & {hz_ms, hz_es};
    ds_fire      = ds_valid & ~stall & es_allow_in;
    // Run length saturates so a very long stall cannot wrap back under the limit.
    run_nxt      = (run_cnt == 8'hff) ? run_cnt : run_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_slot       <= '0;
      ms_slot       <= '0;
      run_cnt       <= '0;
      prev_stall    <= 1'b0;
      stall_timeout <= 1'b0;
      stall_cnt     <= '0;
      hazard_cnt    <= '0;
    end else begin
      prev_stall <= stall;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
        run_cnt   <= run_nxt;
      end else begin
        run_cnt   <= '0;
      end
      if (stall & ~prev_stall)
        hazard_cnt <= hazard_cnt + 32'd1;
      // Sticky: only reset clears it, flush leaves it alone.
      if (stall && run_nxt >= MAX_STALL_W)
        stall_timeout <= 1'b1;

      if (flush) begin
        es_slot.v <= 1'b0;
        ms_slot.v <= 1'b0;
      end else begin
        // The old EXE entry moves down before the new decode entry overwrites it.
        if (es_fire)      ms_slot   <= es_slot;
        else if (ms_fire) ms_slot.v <= 1'b0;
        if (ds_fire)      es_slot   <= {1'b1, ds_is_load, ds_rf_we, ds_rf_waddr};
        else if (es_fire) es_slot.v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_use_interlock.sv
module tb_load_use_interlock;

  logic        clk = 1'b0;
  logic        reset, flush, ds_valid, ds_use1, ds_use2, ds_is_load, ds_rf_we;
  logic [4:0]  ds_raddr1, ds_raddr2, ds_rf_waddr;
  logic        es_allow_in, es_fire, ms_fire;
  logic        stall_a, dsf_a, to_a, stall_b, dsf_b, to_b;
  logic [1:0]  rsn_a, rsn_b;
  logic [31:0] scnt_a, hcnt_a, scnt_b, hcnt_b;

  always #5 clk = ~clk;

  load_use_interlock #(.LOAD_LAT(1), .MAX_STALL(15)) u_lat1 (
    .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2), .ds_use1(ds_use1), .ds_use2(ds_use2),
    .ds_is_load(ds_is_load), .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr),
    .es_allow_in(es_allow_in), .es_fire(es_fire), .ms_fire(ms_fire),
    .stall(stall_a), .stall_reason(rsn_a), .ds_fire(dsf_a), .stall_timeout(to_a),
    .stall_cnt(scnt_a), .hazard_cnt(hcnt_a));

  load_use_interlock #(.LOAD_LAT(2), .MAX_STALL(15)) u_lat2 (
    .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid),
    .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2), .ds_use1(ds_use1), .ds_use2(ds_use2),
    .ds_is_load(ds_is_load), .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr),
    .es_allow_in(es_allow_in), .es_fire(es_fire), .ms_fire(ms_fire),
    .stall(stall_b), .stall_reason(rsn_b), .ds_fire(dsf_b), .stall_timeout(to_b),
    .stall_cnt(scnt_b), .hazard_cnt(hcnt_b));

  typedef struct {
    logic       rst, fl, dv;
    logic [4:0] r1, r2;
    logic       u1, u2, ld, we;
    logic [4:0] wa;
    logic       ea, ef, mf;
    logic       s1;
    logic [1:0] rs1;
    logic       s2;
    logic [1:0] rs2;
    logic       chk;
  } vec_t;

  typedef struct {
    logic       s1, f1, s2, f2;
    logic [1:0] rs1, rs2;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  int    checks = 0, errors = 0;
  int    row = 0;
  // reference tallies for the counters, derived from expected stalls
  int    st_a = 0, hz_a = 0, st_b = 0, hz_b = 0;
  logic  pv_a = 1'b0, pv_b = 1'b0;

  function automatic vec_t mk(input logic rst, fl, dv, input logic [4:0] r1, r2,
                              input logic u1, u2, ld, we, input logic [4:0] wa,
                              input logic ea, ef, mf, s1, input logic [1:0] rs1,
                              input logic s2, input logic [1:0] rs2);
    vec_t v;
    v.rst = rst; v.fl = fl; v.dv = dv; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2;
    v.ld = ld; v.we = we; v.wa = wa; v.ea = ea; v.ef = ef; v.mf = mf;
    v.s1 = s1; v.rs1 = rs1; v.s2 = s2; v.rs2 = rs2; v.chk = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    reset = v.rst; flush = v.fl; ds_valid = v.dv;
    ds_raddr1 = v.r1; ds_raddr2 = v.r2; ds_use1 = v.u1; ds_use2 = v.u2;
    ds_is_load = v.ld; ds_rf_we = v.we; ds_rf_waddr = v.wa;
    es_allow_in = v.ea; es_fire = v.ef; ms_fire = v.mf;
    e.s1 = v.s1; e.rs1 = v.rs1; e.f1 = v.dv & ~v.s1 & v.ea;
    e.s2 = v.s2; e.rs2 = v.rs2; e.f2 = v.dv & ~v.s2 & v.ea;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (v.chk) begin
      check("lat1_stall",   32'(stall_a), 32'(e.s1));
      check("lat1_reason",  32'(rsn_a),   32'(e.rs1));
      check("lat1_ds_fire", 32'(dsf_a),   32'(e.f1));
      check("lat2_stall",   32'(stall_b), 32'(e.s2));
      check("lat2_reason",  32'(rsn_b),   32'(e.rs2));
      check("lat2_ds_fire", 32'(dsf_b),   32'(e.f2));
    end
    if (!v.rst) begin
      check("lat1_stall_cnt",  scnt_a, 32'(st_a));
      check("lat1_hazard_cnt", hcnt_a, 32'(hz_a));
      check("lat2_stall_cnt",  scnt_b, 32'(st_b));
      check("lat2_hazard_cnt", hcnt_b, 32'(hz_b));
    end
    if (v.rst) begin
      st_a = 0; hz_a = 0; pv_a = 1'b0; st_b = 0; hz_b = 0; pv_b = 1'b0;
    end else begin
      st_a += int'(v.s1); hz_a += int'(v.s1 & ~pv_a); pv_a = v.s1;
      st_b += int'(v.s2); hz_b += int'(v.s2 & ~pv_b); pv_b = v.s2;
    end
    row++;
  endtask

  // drains two cycles: EXE->MEM, then MEM->WB
  task automatic drain();
    apply(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    apply(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
  endtask

  initial begin
    vec_t v;
    //            rst fl dv r1 r2 u1 u2 ld we wa ea ef mf s1 rs1 s2 rs2
    tbl.push_back(mk(1,0,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0));
    tbl[0].chk = 1'b0;
    tbl.push_back(mk(1,0,1, 5,5, 1,1,1,1, 5, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0));
    // ld r5 ; add r6,r5,r7
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 5, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 5,7, 1,1,0,1, 6, 1,1,0, 1,1,1,1));
    tbl.push_back(mk(0,0,1, 5,7, 1,1,0,1, 6, 0,0,1, 0,0,1,2));
    tbl.push_back(mk(0,0,1, 5,7, 1,1,0,1, 6, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
    // ld r0 ; consumer of r0
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 0, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 0,0, 1,0,0,1, 6, 1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
    // ld r5 ; consumer naming r5 but reading neither source
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 5, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 5,5, 0,0,0,1, 6, 1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 5,5, 0,0,0,1, 6, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
    // ALU producer of r5 ; consumer: forwarded, no stall
    tbl.push_back(mk(0,0,1, 0,0, 0,0,0,1, 5, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 5,0, 1,0,0,1, 6, 1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
    // ld r1 ; ld r2 ; add r9,r1,r2
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 1, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 2, 1,1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,1, 1,2, 1,1,0,1, 9, 0,1,1, 1,1,1,3));
    tbl.push_back(mk(0,0,1, 1,2, 1,1,0,1, 9, 0,0,1, 0,0,1,2));
    tbl.push_back(mk(0,0,1, 1,2, 1,1,0,1, 9, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0, 0,0,0,0, 0, 1,0,1, 0,0,0,0));
    // ld r4 ; consumer invalid (gated) ; flush during hazard ; consumer issues
    tbl.push_back(mk(0,0,1, 0,0, 0,0,1,1, 4, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 4,0, 1,0,0,1, 6, 1,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,1, 4,0, 1,0,0,1, 6, 1,0,0, 1,1,1,1));
    tbl.push_back(mk(0,0,1, 4,0, 1,0,0,1, 6, 1,0,0, 0,0,0,0));

    foreach (tbl[i]) apply(tbl[i]);
    drain();
    check("lat1_timeout_idle", 32'(to_a), 32'd0);
    check("lat2_timeout_idle", 32'(to_b), 32'd0);

    // Watchdog: ld r8 stuck in EXE for 20 stall cycles, then moves on.
    apply(mk(0,0,1, 0,0, 0,0,1,1, 8, 1,0,0, 0,0,0,0));
    for (int k = 0; k < 20; k++) begin
      apply(mk(0,0,1, 8,0, 1,0,0,1, 3, 0, (k == 19), 0, 1,1,1,1));
      if (k <= 13) begin
        check("lat1_timeout_early", 32'(to_a), 32'd0);
        check("lat2_timeout_early", 32'(to_b), 32'd0);
      end else if (k >= 16) begin
        check("lat1_timeout_set", 32'(to_a), 32'd1);
        check("lat2_timeout_set", 32'(to_b), 32'd1);
      end
    end
    apply(mk(0,0,1, 8,0, 1,0,0,1, 3, 0,0,1, 0,0,1,2));
    apply(mk(0,0,1, 8,0, 1,0,0,1, 3, 1,0,0, 0,0,0,0));
    check("lat1_timeout_sticky", 32'(to_a), 32'd1);
    check("lat2_timeout_sticky", 32'(to_b), 32'd1);
    apply(mk(0,1,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0));
    apply(mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0));
    check("lat1_timeout_after_flush", 32'(to_a), 32'd1);
    check("lat2_timeout_after_flush", 32'(to_b), 32'd1);

    // Reset in the middle of a stall: stall drops the next cycle.
    apply(mk(0,0,1, 0,0, 0,0,1,1, 8, 1,0,0, 0,0,0,0));
    apply(mk(0,0,1, 8,0, 1,0,0,1, 3, 0,0,0, 1,1,1,1));
    apply(mk(1,0,1, 8,0, 1,0,0,1, 3, 0,0,0, 1,1,1,1));
    apply(mk(0,0,1, 8,0, 1,0,0,1, 3, 1,0,0, 0,0,0,0));
    check("lat1_timeout_reset", 32'(to_a), 32'd0);
    check("lat2_timeout_reset", 32'(to_b), 32'd0);
    v = mk(0,0,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0,0);
    apply(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_use_interlock.md
Name: load_use_interlock

Overview:
- Hazard/interlock controller for the 5-stage pipeline. Sits beside the decode stage and drives that stage's `stall` input.
- Keeps a shadow copy of the destination-register info for the instructions in EXE and MEM. From it, detects load-use hazards that the EXE/MEM/WB forwarding network cannot cover, because load data is not valid until the end of the load-latency window.
- Also provides an external pipeline flush, a stall watchdog, and performance counters.

Parameters:
- LOAD_LAT, 1: stages a load occupies before its data is forwardable. 1 = data forwardable from MEM. 2 = data forwardable from WB. Legal values 1, 2.
- MAX_STALL, 15: consecutive stall cycles tolerated before `stall_timeout` asserts (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; invalidates both shadow slots
- ds_valid  in  1  decode stage holds a valid instruction
- ds_raddr1  in  5  decode source register 1 (rj)
- ds_raddr2  in  5  decode source register 2 (rk or rd)
- ds_use1  in  1  instruction actually reads raddr1
- ds_use2  in  1  instruction actually reads raddr2
- ds_is_load  in  1  decoded instruction is ld.w
- ds_rf_we  in  1  decoded instruction writes the register file
- ds_rf_waddr  in  5  decoded destination register
- es_allow_in  in  1  EXE can accept
- es_fire  in  1  EXE instruction moves to MEM this cycle
- ms_fire  in  1  MEM instruction moves to WB this cycle
- stall  out  1  hold decode (combinational)
- stall_reason  out  2  00 none, 01 load in EXE, 10 load in MEM, 11 both
- ds_fire  out  1  ds_valid & ~stall & es_allow_in
- stall_timeout  out  1  sticky watchdog flag
- stall_cnt  out  32  total stall cycles
- hazard_cnt  out  32  number of distinct load-use stall events

Behaviour:
- Shadow slots es_slot and ms_slot, each {v, ld, we, waddr}.
- Reset values:
  - both slots v=0, other fields 0
  - stall_timeout=0, stall_cnt=0, hazard_cnt=0
  - internal run counter=0, prev_stall=0
- Combinational outputs:
  - stall=0 whenever slots are invalid or ds_valid=0.
- Slot update, priority order per clock edge:
  1. reset
  2. flush: both v<=0
  3. normal update:
     - ms_slot<=es_slot when es_fire; else ms.v<=0 when ms_fire; else hold.
     - es_slot<={1, ds_is_load, ds_rf_we, ds_rf_waddr} when ds_fire; else es.v<=0 when es_fire; else hold.
  - es_fire and ds_fire in the same cycle: the old es_slot moves to MS and the new instruction enters ES, both at the same edge.
- Hazard match for slot s and register r, usage u: `s.v & s.ld & s.we & (s.waddr!=0) & (s.waddr==r) & u`.
  - hz_es = match(es,raddr1,use1) | match(es,raddr2,use2)
  - hz_ms = (LOAD_LAT==2) & (match(ms,raddr1,use1) | match(ms,raddr2,use2))
  - stall = ds_valid & (hz_es | hz_ms); stall_reason = {hz_ms, hz_es} gated by ds_valid.
  - r0 never stalls. Non-load producers never stall (they are covered by forwarding).
- Stall duration:
  - Load in EXE, LOAD_LAT=1: stall lasts until es_fire. The next cycle has no stall from that load.
  - LOAD_LAT=2: stall continues while the load sits in MEM, and ends after ms_fire.
- Counters:
  - stall_cnt += 1 each cycle stall=1; wraps modulo 2^32.
  - hazard_cnt += 1 on cycles where stall=1 & prev_stall=0; prev_stall is registered stall.
  - run counter: 8-bit. Increments while stall=1, clears when stall=0, saturates at 255.
  - stall_timeout <= 1 when run counter reaches MAX_STALL while stall=1. Stays 1 until reset; flush does not clear it.
- flush in the same cycle as a hazard:
  - stall still computed from pre-flush slots that cycle.
  - Slots are empty the next cycle, so no stall.
- Reset mid-stall: stall drops the cycle after reset is sampled (slots invalid).

Test Plan:
1. LOAD_LAT=1. Issue ld.w r5 (ds_fire). Next cycle decode add r6,r5,r7 with use1=1 → stall=1, stall_reason=01 for one cycle. es_fire → stall=0 next cycle. stall_cnt=1, hazard_cnt=1.
2. Same sequence with ld.w r0 as the producer, or with the consumer having use1=use2=0 → stall stays 0; counters stay 0.
3. LOAD_LAT=2. ld.w r3, then immediately beq r3,r4 (use1) → stall 2 cycles (reason 01 then 10). Clears after ms_fire. stall_cnt=2, hazard_cnt=1.
4. ld.w r8 in EXE with es_allow_in=0 and es_fire held low 20 cycles, consumer of r8 in decode, MAX_STALL=15 → stall_timeout rises on the 15th stall cycle and stays 1 after the stall ends. stall_cnt=20.
5. Hazard active (stall=1) with flush pulsed for one cycle → stall=0 the following cycle, es.v=ms.v=0. A subsequent independent instruction issues with ds_fire=1.
6. Back-to-back: ld.w r1 then ld.w r2 (independent), then add r9,r1,r2 at LOAD_LAT=2 → stall while r2's load is in EXE and r1's is in MEM (reason 11), then 10. hazard_cnt=1.
